// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-lookahead adder.
package pipelined_cla_adder_pkg;

  localparam int GRP_W = 4;

  function automatic bit width_legal(input int w);
    return (w >= GRP_W) && ((w % GRP_W) == 0);
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result stream bundle for the pipelined adder: valid/ready on both sides.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla_adder_cla4_group.sv
// 4-bit carry-lookahead group: sum plus group propagate/generate and carry-out.
module cla4_group
  import pipelined_cla_adder_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             c,
  output logic [GRP_W-1:0] s,
  output logic             p,
  output logic             g,
  output logic             co
);

  logic [GRP_W-1:0] pi;
  logic [GRP_W-1:0] gi;
  logic [GRP_W:0]   cc;

  always_comb begin
    pi    = a ^ b;
    gi    = a & b;
    cc[0] = c;
    cc[1] = gi[0] | (pi[0] & c);
    cc[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & c);
    cc[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
          | (pi[2] & pi[1] & pi[0] & c);
    g     = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
          | (pi[3] & pi[2] & pi[1] & gi[0]);
    p     = &pi;
    cc[4] = g | (p & c);
    s     = pi ^ cc[GRP_W-1:0];
    co    = cc[GRP_W];
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Adder/subtractor pipelined one 4-bit lookahead group per stage, with skewed
// operands going in and deskewed result groups coming out.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  pipelined_cla_adder_if.slave bus
);

  localparam int NGRP = WIDTH / GRP_W;

  if (!width_legal(WIDTH)) begin : g_width_chk
    $fatal(1, "pipelined_cla_adder: WIDTH must be a multiple of 4, at least 4");
  end

  // Each stage word holds finished result groups below k and still-pending A groups above.
  logic [WIDTH-1:0] word_q  [NGRP];
  logic [WIDTH-1:0] word_d  [NGRP];
  logic [WIDTH-1:0] b_q     [NGRP];
  logic [WIDTH-1:0] b_d     [NGRP];
  logic             carry_q [NGRP];
  logic             carry_d [NGRP];
  logic             vld_q   [NGRP];
  logic             vld_d   [NGRP];
  logic             ovf_q;
  logic             ovf_d;

  logic [WIDTH-1:0] src_word [NGRP];
  logic [WIDTH-1:0] src_b    [NGRP];
  logic             src_c    [NGRP];
  logic             src_v    [NGRP];

  logic [GRP_W-1:0] grp_a  [NGRP];
  logic [GRP_W-1:0] grp_b  [NGRP];
  logic [GRP_W-1:0] grp_s  [NGRP];
  logic             grp_c  [NGRP];
  logic             grp_p  [NGRP];
  logic             grp_g  [NGRP];
  logic             grp_co [NGRP];

  logic adv;
  logic c_msb;

  assign adv           = !vld_q[NGRP-1] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[NGRP-1];
  assign bus.sum       = word_q[NGRP-1];
  assign bus.cout      = carry_q[NGRP-1];
  assign bus.ovf       = ovf_q;

  // Subtraction is A + ~B + 1, so cin is ignored when sub is set.
  always_comb begin
    src_word[0] = bus.a;
    src_b[0]    = bus.sub ? ~bus.b : bus.b;
    src_c[0]    = bus.sub | bus.cin;
    src_v[0]    = bus.in_valid;
    for (int k = 1; k < NGRP; k++) begin
      src_word[k] = word_q[k-1];
      src_b[k]    = b_q[k-1];
      src_c[k]    = carry_q[k-1];
      src_v[k]    = vld_q[k-1];
    end
    for (int k = 0; k < NGRP; k++) begin
      grp_a[k] = src_word[k][GRP_W*k +: GRP_W];
      grp_b[k] = src_b[k][GRP_W*k +: GRP_W];
      grp_c[k] = src_c[k];
    end
  end

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    cla4_group u_grp (
      .a  (grp_a[k]),
      .b  (grp_b[k]),
      .c  (grp_c[k]),
      .s  (grp_s[k]),
      .p  (grp_p[k]),
      .g  (grp_g[k]),
      .co (grp_co[k])
    );
  end

  // NOTE: every variable written here gets a full value on every pass, so no latches form.
  always_comb begin
    for (int k = 0; k < NGRP; k++) begin
      word_d[k]                     = src_word[k];
      word_d[k][GRP_W*k +: GRP_W]   = grp_s[k];
      b_d[k]                        = src_b[k];
      carry_d[k]                    = grp_g[k] | (grp_p[k] & grp_c[k]);
      vld_d[k]                      = src_v[k];
    end
    c_msb = grp_s[NGRP-1][GRP_W-1] ^ grp_a[NGRP-1][GRP_W-1] ^ grp_b[NGRP-1][GRP_W-1];
    ovf_d = c_msb ^ grp_co[NGRP-1];
  end

  // NOTE: state uses non-blocking assignments; datapath registers are reset too so
  // sum/cout/ovf read 0 out of reset, and everything freezes while adv is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NGRP; k++) begin
        word_q[k]  <= '0;
        b_q[k]     <= '0;
        carry_q[k] <= 1'b0;
        vld_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      word_q  <= word_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed-vector and scoreboard bench for pipelined_cla_adder at WIDTH=16.
module tb_pipelined_cla_adder;

  localparam int WIDTH = 16;
  localparam int LAT   = 4;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(WIDTH)) bus_if ();

  pipelined_cla_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  res_t sb_q[$];
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    logic [15:0] be;
    logic [16:0] full;
    res_t        r;
    be     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, be} + {16'd0, (sub ? 1'b1 : cin)};
    r.sum  = full[15:0];
    r.cout = full[16];
    r.ovf  = (a[15] == be[15]) && (full[15] != a[15]);
    return r;
  endfunction

  // Scoreboard: every presented result must match the oldest outstanding beat.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (bus_if.out_valid) begin
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          check("sb_sum",  32'(bus_if.sum),  32'(sb_q[0].sum));
          check("sb_cout", 32'(bus_if.cout), 32'(sb_q[0].cout));
          check("sb_ovf",  32'(bus_if.ovf),  32'(sb_q[0].ovf));
          if (bus_if.out_ready) begin
            void'(sb_q.pop_front());
            n_out++;
          end
        end
      end
      if (bus_if.in_valid && bus_if.in_ready)
        sb_q.push_back(model(bus_if.a, bus_if.b, bus_if.cin, bus_if.sub));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input vec_t v);
    bus_if.a   = v.a;
    bus_if.b   = v.b;
    bus_if.cin = v.cin;
    bus_if.sub = v.sub;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input vec_t v, input string tag);
    int lat;
    drive(v);
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    lat = 1;
    while (!bus_if.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_sum"},  32'(bus_if.sum),  32'(v.sum));
    check({tag, "_cout"}, 32'(bus_if.cout), 32'(v.cout));
    check({tag, "_ovf"},  32'(bus_if.ovf),  32'(v.ovf));
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'd0);
    check({tag, "_in_ready"},  32'(bus_if.in_ready),  32'd1);
    check({tag, "_sum"},       32'(bus_if.sum),       32'd0);
    check({tag, "_cout"},      32'(bus_if.cout),      32'd0);
    check({tag, "_ovf"},       32'(bus_if.ovf),       32'd0);
  endtask

  initial begin
    int  i;
    int  out0;
    int  acc_n;
    int  cyc;
    logic acc;

    //            a         b         cin   sub   sum       cout  ovf
    vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2]  = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[6]  = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[9]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[10] = '{16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[11] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.a         = '0;
    bus_if.b         = '0;
    bus_if.cin       = 1'b0;
    bus_if.sub       = 1'b0;
    bus_if.out_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Isolated beats: exact latency and hand-computed results.
    for (int k = 0; k < 12; k++)
      run_single(vecs[k], $sformatf("vec%0d", k));

    // Back-to-back stream with out_ready low in cycles 5..7.
    i    = 0;
    out0 = n_out;
    for (int c = 0; c < 40 && (i < 8 || sb_q.size() != 0); c++) begin
      bus_if.out_ready = !(c >= 5 && c <= 7);
      if (i < 8) begin
        drive(vecs[i]);
        bus_if.in_valid = 1'b1;
      end else begin
        bus_if.in_valid = 1'b0;
      end
      #1;
      if (c >= 5 && c <= 7)
        check($sformatf("stall_in_ready_c%0d", c), 32'(bus_if.in_ready), 32'd0);
      acc = bus_if.in_valid && bus_if.in_ready;
      tick();
      if (acc) i++;
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    check("stall_beats_accepted", 32'(i), 32'd8);
    check("stall_beats_out", 32'(n_out - out0), 32'd8);

    // Three beats in flight, one-cycle reset right after the third.
    for (int j = 0; j < 3; j++) begin
      drive(vecs[j + 3]);
      bus_if.in_valid = 1'b1;
      tick();
    end
    bus_if.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst = 1'b0;
    for (int j = 0; j < 8; j++) begin
      check($sformatf("post_rst_quiet_%0d", j), 32'(bus_if.out_valid), 32'd0);
      tick();
    end
    run_single(vecs[5], "post_rst");

    // Reset while a result is stalled at the output.
    drive(vecs[1]);
    bus_if.out_ready = 1'b0;
    bus_if.in_valid  = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    cyc = 0;
    while (!bus_if.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("held_out_valid", 32'(bus_if.out_valid), 32'd1);
    check("held_in_ready", 32'(bus_if.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check_reset_outputs("heldrst");
    tick();
    rst              = 1'b0;
    bus_if.out_ready = 1'b1;
    tick();
    check("heldrst_quiet", 32'(bus_if.out_valid), 32'd0);

    // Random traffic against the scoreboard.
    acc_n = 0;
    cyc   = 0;
    while (acc_n < 10000 && cyc < 60000) begin
      bus_if.a         = 16'($urandom);
      bus_if.b         = 16'($urandom);
      bus_if.cin       = 1'($urandom_range(0, 1));
      bus_if.sub       = 1'($urandom_range(0, 1));
      bus_if.in_valid  = ($urandom_range(0, 3) != 0);
      bus_if.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = bus_if.in_valid && bus_if.in_ready;
      tick();
      if (acc) acc_n++;
      cyc++;
    end
    check("rand_beats_accepted", 32'(acc_n), 32'd10000);
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 100) begin
      tick();
      cyc++;
    end
    tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("final_out_valid", 32'(bus_if.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; legal values are multiples of 4, minimum 4.
REQ-002 SHALL derive localparam NGRP = WIDTH/4: the number of 4-bit lookahead groups, which is also the number of pipeline stages.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned/two's complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, used only when sub=0.
REQ-010 sub  input  1  1 = subtract (A-B), 0 = add (A+B+cin).
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
REQ-015 ovf  output  1  signed overflow = carry into MSB XOR cout.

Function
REQ-016 Effective operand SHALL be B when sub=0 and ~B when sub=1; effective carry-in SHALL be cin when sub=0 and 1 when sub=1.
REQ-017 Stage k (0..NGRP-1) SHALL compute group k bits [4k+3:4k] with 4-bit carry lookahead, using the carry registered by stage k-1 (stage 0 uses the effective carry-in).
REQ-018 Operand bits of groups above k SHALL be carried forward in skew registers; result bits of completed groups SHALL be carried forward in deskew registers.
REQ-019 Latency SHALL be exactly NGRP cycles from the in_valid&&in_ready edge to out_valid, absent stalls.
REQ-020 Throughput SHALL be one beat per cycle when out_ready is held 1.
REQ-021 Each stage SHALL hold a valid bit; the pipeline advances when adv = !out_valid || out_ready.
REQ-022 in_ready SHALL equal adv (combinational); when adv=0, all stages, including valid bits, SHALL hold.
REQ-023 Beats SHALL emerge in acceptance order with no loss or duplication under any out_ready pattern.
REQ-024 A beat is transferred out on out_valid && out_ready; sum/cout/ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Bubbles (in_valid=0 when adv=1) SHALL propagate as valid=0 stages; output data under out_valid=0 is don't-care.
REQ-026 Accept and emit in the same cycle SHALL both occur.
REQ-027 For WIDTH=4 the block SHALL be a single registered stage with latency 1.

Reset
REQ-028 On rst=1, all valid bits and out_valid SHALL clear to 0 immediately; sum, cout, and ovf SHALL clear to 0.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; no result from a pre-reset beat SHALL appear after reset.
REQ-030 in_ready SHALL be 1 during and after reset (adv=1 when out_valid=0).

Structure
REQ-031 A shared package SHALL hold GRP_W = 4 and a width-legality check function used for an elaboration assertion.
REQ-032 A combinational sub-module cla4_group SHALL compute 4-bit sum, group P, group G, and carry-out from a, b, and c; it SHALL be instantiated NGRP times via generate.
REQ-033 The implementation SHALL NOT use the '+' operator for the datapath.

Verification (WIDTH=16, latency 4)
REQ-034 a=0xFFFF, b=0x0001, sub=0, cin=0 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
REQ-035 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1; a=0x0FFF, b=0x0000, cin=1 -> sum=0x1000 (carry crosses 3 groups).
REQ-036 a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
REQ-037 Stream 8 back-to-back beats; hold out_ready=0 for cycles 5-7 -> in_ready=0 those cycles, all 8 results correct, in order, none lost.
REQ-038 Accept 3 beats, assert rst for 1 cycle on the cycle after the third -> out_valid=0 at once, no stale result appears, and the next accepted beat appears after exactly 4 cycles.
REQ-039 Random self-checking run of 10k beats with random in_valid/out_ready against a scoreboard -> zero mismatches.
